fire8_squeeze_ram: RTL and testbench

- Feature-map buffer directly downstream of the fire8 squeeze layer.
- Captures each DSP_NO-channel output vector on the squeeze sample pulse until all WOUT*WOUT pixels are stored, then raises ram_feedback.
- Then streams the stored map one WIDTH-bit word per accepted request, pixel-major and channel-minor, as the scalar ifm feed for the fire8 expand layers.

---
 rtl/fire8_pkg.sv | 17 +
 rtl/fire8_squeeze_ram_if.sv | 31 +++
 rtl/fire8_squeeze_rowbuf.sv | 23 ++
 rtl/fire8_squeeze_ram.sv | 122 ++++++++++++
 tb/tb_fire8_squeeze_ram.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fire8_pkg.sv
// Shared types and sizing for the fire8 squeeze feature-map buffer.
package fire8_pkg;

  localparam int FIRE8_WIDTH = 16;
  localparam int FIRE8_SQ_CH = 112;
  localparam int FIRE8_WOUT  = 8;
  localparam int FIRE8_PIX   = 64;

  typedef logic [FIRE8_WIDTH-1:0] act_t;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    DONE
  } buf_state_e;

endpackage

// File: rtl/fire8_squeeze_ram_if.sv
// Squeeze-side write bus and expand-side read stream of the fire8 squeeze buffer.
interface fire8_squeeze_ram_if
  import fire8_pkg::*;
#(
  parameter int WIDTH  = FIRE8_WIDTH,
  parameter int DSP_NO = FIRE8_SQ_CH
);

  logic             wr_sample;
  logic [WIDTH-1:0] wr_data [DSP_NO];
  logic             ram_feedback;
  logic             full;
  logic             rd_en;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;
  logic             drain_done;
  logic             overflow;

  // master is the surrounding datapath (squeeze producer plus expand consumer)
  modport master (
    output wr_sample, wr_data, rd_en,
    input  ram_feedback, full, rd_valid, rd_data, rd_last, drain_done, overflow
  );

  modport slave (
    input  wr_sample, wr_data, rd_en,
    output ram_feedback, full, rd_valid, rd_data, rd_last, drain_done, overflow
  );

endinterface

// File: rtl/fire8_squeeze_rowbuf.sv
// Row storage: synchronous full-row write, combinational single-row read, no reset.
module fire8_squeeze_rowbuf #(
  parameter int ROW_W = 1792,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [ROW_W-1:0] wrow,
  input  logic [AW-1:0]    raddr,
  output logic [ROW_W-1:0] rrow
);

  logic [ROW_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wrow;
  end

  assign rrow = mem[raddr];

endmodule

// File: rtl/fire8_squeeze_ram.sv
// Fire8 squeeze feature-map buffer: fills WOUT*WOUT channel vectors, then streams
// them one word per accepted request, pixel-major and channel-minor.
module fire8_squeeze_ram
  import fire8_pkg::*;
#(
  parameter int WIDTH  = FIRE8_WIDTH,
  parameter int DSP_NO = FIRE8_SQ_CH,
  parameter int WOUT   = FIRE8_WOUT
) (
  input logic                clk,
  input logic                rst,
  fire8_squeeze_ram_if.slave bus
);

  localparam int PIX   = WOUT * WOUT;
  localparam int PIX_W = $clog2(PIX);
  localparam int CH_W  = $clog2(DSP_NO);
  localparam int ROW_W = DSP_NO * WIDTH;

  buf_state_e       state;
  logic [PIX_W:0]   wr_ptr;
  logic [PIX_W-1:0] rd_pix;
  logic [CH_W-1:0]  rd_ch;
  logic [ROW_W-1:0] wrow;
  logic [ROW_W-1:0] rrow;
  logic             wr_en;
  logic             rd_accept;
  logic             last_word;

  logic             ram_feedback_q;
  logic             full_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_last_q;
  logic             drain_done_q;
  logic             overflow_q;

  always_comb begin
    wrow = '0;
    for (int c = 0; c < DSP_NO; c++) wrow[c*WIDTH +: WIDTH] = bus.wr_data[c];
  end

  assign wr_en     = (state == FILL) && bus.wr_sample;
  assign rd_accept = (state == DRAIN) && bus.rd_en;
  assign last_word = (rd_pix == PIX_W'(PIX - 1)) && (rd_ch == CH_W'(DSP_NO - 1));

  fire8_squeeze_rowbuf #(
    .ROW_W (ROW_W),
    .DEPTH (PIX),
    .AW    (PIX_W)
  ) u_rowbuf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[PIX_W-1:0]),
    .wrow  (wrow),
    .raddr (rd_pix),
    .rrow  (rrow)
  );

  // Writes outside FILL never reach storage; they only raise the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= FILL;
      wr_ptr         <= '0;
      rd_pix         <= '0;
      rd_ch          <= '0;
      ram_feedback_q <= 1'b0;
      full_q         <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_last_q      <= 1'b0;
      drain_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      ram_feedback_q <= 1'b0;
      rd_valid_q     <= rd_accept;
      rd_last_q      <= 1'b0;
      case (state)
        FILL: begin
          if (bus.wr_sample) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == (PIX_W + 1)'(PIX - 1)) begin
              ram_feedback_q <= 1'b1;
              full_q         <= 1'b1;
              state          <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.wr_sample) overflow_q <= 1'b1;
          if (bus.rd_en) begin
            rd_data_q <= rrow[int'(rd_ch)*WIDTH +: WIDTH];
            if (last_word) begin
              rd_last_q    <= 1'b1;
              drain_done_q <= 1'b1;
              full_q       <= 1'b0;
              state        <= DONE;
            end else if (rd_ch == CH_W'(DSP_NO - 1)) begin
              rd_ch  <= '0;
              rd_pix <= rd_pix + 1'b1;
            end else begin
              rd_ch <= rd_ch + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.wr_sample) overflow_q <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.ram_feedback = ram_feedback_q;
  assign bus.full         = full_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_last      = rd_last_q;
  assign bus.drain_done   = drain_done_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_fire8_squeeze_ram.sv
// Randomised scoreboard bench for fire8_squeeze_ram against a pixel/channel array model.
module tb_fire8_squeeze_ram;
  import fire8_pkg::*;

  localparam int PIX   = FIRE8_PIX;
  localparam int CH    = FIRE8_SQ_CH;
  localparam int BEATS = PIX * CH;

  typedef struct packed {
    act_t data;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fire8_squeeze_ram_if #(.WIDTH(FIRE8_WIDTH), .DSP_NO(CH)) bus ();

  fire8_squeeze_ram #(
    .WIDTH  (FIRE8_WIDTH),
    .DSP_NO (CH),
    .WOUT   (FIRE8_WOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  act_t ref_mem [PIX][CH];
  int   vectors     = 0;
  int   miscompares = 0;
  int   fb_count    = 0;
  int   fb_expected = 0;

  function automatic void check(string name, longint actual, longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Monitor: every presented word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_feedback) fb_count++;
      if (bus.rd_last && !bus.rd_valid) check("rd_last_without_valid", 1, 0);
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rd_data", bus.rd_data, e.data);
          check("rd_last", bus.rd_last, e.last);
        end
      end
      if (exp_q.size() > 1) check("rd_valid_latency", exp_q.size(), 1);
    end
  end

  task automatic check_output_reset();
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_last", bus.rd_last, 0);
    check("rst_ram_feedback", bus.ram_feedback, 0);
    check("rst_full", bus.full, 0);
    check("rst_drain_done", bus.drain_done, 0);
    check("rst_overflow", bus.overflow, 0);
  endtask

  task automatic do_reset();
    bus.rd_en     = 1'b0;
    bus.wr_sample = 1'b0;
    rst = 1'b0;
    #1;
    check_output_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // mode 0: pix*256+ch, mode 1: pix*256+ch+1, otherwise random words
  task automatic fill_map(input int mode, input int gap, input int rd_pulses);
    int pulses = rd_pulses;
    check("full_before_fill", bus.full, 0);
    check("overflow_before_fill", bus.overflow, 0);
    for (int p = 0; p < PIX; p++) begin
      for (int c = 0; c < CH; c++) begin
        act_t v;
        if (mode == 0)      v = act_t'(p * 256 + c);
        else if (mode == 1) v = act_t'(p * 256 + c + 1);
        else                v = act_t'($urandom);
        ref_mem[p][c]   = v;
        bus.wr_data[c]  = v;
      end
      if (p == PIX - 1) check("full_pre_last_write", bus.full, 0);
      bus.wr_sample = 1'b1;
      bus.rd_en     = (p == PIX - 1);
      @(posedge clk);
      #1;
      bus.wr_sample = 1'b0;
      bus.rd_en     = 1'b0;
      if (p != PIX - 1) begin
        for (int g = 1; g < gap; g++) begin
          bus.rd_en = (p >= 10 && pulses > 0 && g == 1);
          if (bus.rd_en) pulses--;
          @(posedge clk);
          #1;
          bus.rd_en = 1'b0;
        end
      end
    end
    fb_expected++;
    check("ram_feedback_rise", bus.ram_feedback, 1);
    check("full_set", bus.full, 1);
    check("rd_valid_in_fill", bus.rd_valid, 0);
    @(posedge clk);
    #1;
    check("ram_feedback_one_cycle", bus.ram_feedback, 0);
    check("full_held", bus.full, 1);
    check("rd_valid_after_last_write", bus.rd_valid, 0);
    check("ram_feedback_count", fb_count, fb_expected);
  endtask

  // mode 0: rd_en held, 1: alternating, otherwise random; abort_at < 0 means no reset
  task automatic drain_map(input int mode, input int abort_at, input bit inject_ovf);
    int k = 0;
    int cycles = 0;
    bit en;
    bit injected = 1'b0;
    while (k < BEATS) begin
      if (cycles > 4 * BEATS) begin
        check("drain_cycle_budget", cycles, 4 * BEATS);
        break;
      end
      if (k == abort_at) begin
        do_reset();
        return;
      end
      if (mode == 0)      en = 1'b1;
      else if (mode == 1) en = (cycles % 2 == 0);
      else                en = ($urandom_range(0, 3) != 0);
      bus.rd_en = en;
      if (inject_ovf && !injected && k == 500 && en) begin
        injected = 1'b1;
        bus.wr_sample = 1'b1;
        for (int c = 0; c < CH; c++) bus.wr_data[c] = 16'hFFFF;
      end
      if (en) begin
        exp_q.push_back({ref_mem[k / CH][k % CH], (k == BEATS - 1)});
        k++;
      end
      @(posedge clk);
      #1;
      bus.wr_sample = 1'b0;
      cycles++;
    end
    bus.rd_en = 1'b0;
    check("drain_done_set", bus.drain_done, 1);
    check("full_cleared", bus.full, 0);
    check("overflow_after_drain", bus.overflow, inject_ovf);
    // Requests and writes after the stream must be ignored apart from overflow.
    bus.rd_en     = 1'b1;
    bus.wr_sample = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.rd_en     = 1'b0;
    bus.wr_sample = 1'b0;
    @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("drain_done_sticky", bus.drain_done, 1);
    check("rd_valid_in_done", bus.rd_valid, 0);
    check("overflow_in_done", bus.overflow, 1);
    check("full_in_done", bus.full, 0);
  endtask

  initial begin
    #1000000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.wr_sample = 1'b0;
    bus.rd_en     = 1'b0;
    for (int c = 0; c < CH; c++) bus.wr_data[c] = '0;
    #2;
    do_reset();

    $display("[TB] fill with pix*256+ch, reads during fill, full drain with overflow pulse");
    fill_map(0, 10, 20);
    drain_map(0, -1, 1'b1);

    $display("[TB] refill with +1 pattern, alternating reads, reset at beat 3000");
    do_reset();
    fill_map(1, 2, 0);
    drain_map(1, 3000, 1'b0);

    $display("[TB] refill with +1 pattern after reset, alternating reads to completion");
    fill_map(1, 1, 0);
    drain_map(1, -1, 1'b0);

    $display("[TB] random data, random read requests");
    do_reset();
    fill_map(2, 1, 0);
    drain_map(2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
